// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter.
// Each byte is sent LSB first, framed as 8N1 by default.
// Define UART_TX_PARITY_EN to add an even-parity bit, which makes the frame 8E1.
// The tx, busy, fifo_level and overflow outputs are all driven from registered state.
module uart_tx_fifo #(
   parameter int CLK_DIV    = 16,   // clk cycles per serial bit, >= 2
   parameter int FIFO_DEPTH = 4     // power of 2, >= 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          ena,
   input  logic [7:0]                    din,
   input  logic                          din_valid,
   output logic                          din_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(CLK_DIV);
   localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] ST_PARITY = 3'd4;
`endif

   // ---------------- FIFO ----------------
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [LW-1:0] level_reg, level_next;
   logic          overflow_reg;
   logic          push, pop;

   // Readiness depends only on the stored level.
   // A full FIFO therefore refuses a push even on a cycle where it pops.
   assign din_ready  = (level_reg != LEVEL_FULL);
   assign push       = din_valid && din_ready;
   assign fifo_level = level_reg;
   assign overflow   = overflow_reg;

   // Storage write: the array has no reset, so the tools can map it to RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   // Next level: a simultaneous push and pop cancel out.
   always_comb begin
      level_next = level_reg;
      case ({push, pop})
         2'b10:   level_next = level_reg + 1'b1;
         2'b01:   level_next = level_reg - 1'b1;
         default: level_next = level_reg;
      endcase
   end

   // Pointer, level and sticky-overflow registers.
   // The pointers wrap naturally because the depth is a power of 2.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         level_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         level_reg <= level_next;
         if (din_valid && !din_ready) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   // ---------------- transmitter ----------------
   logic [2:0]    state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [2:0]    bit_idx_reg, bit_idx_next;
   logic [7:0]    byte_reg, byte_next;
   logic          tx_reg, tx_next;
   logic          cnt_done;
   logic          start_ok;

   assign cnt_done = (cnt_reg == CNT_LAST);
   assign start_ok = ena && (level_reg != '0);
   assign tx       = tx_reg;
   assign busy     = (state_reg != ST_IDLE);

   // Frame sequencing.
   // Every state change loads the tx level for the next bit, so tx is always registered.
   // Leaving STOP with data still queued starts the next frame without an idle gap.
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      bit_idx_next = bit_idx_reg;
      byte_next    = byte_reg;
      tx_next      = tx_reg;
      pop          = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start_ok) begin
               pop        = 1'b1;
               byte_next  = mem[rd_ptr_reg];
               cnt_next   = '0;
               tx_next    = 1'b0;
               state_next = ST_START;
            end
         end
         ST_START: begin
            if (cnt_done) begin
               cnt_next     = '0;
               bit_idx_next = 3'd0;
               tx_next      = byte_reg[0];
               state_next   = ST_DATA;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         ST_DATA: begin
            if (cnt_done) begin
               cnt_next = '0;
               if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  tx_next    = ^byte_reg;
                  state_next = ST_PARITY;
`else
                  tx_next    = 1'b1;
                  state_next = ST_STOP;
`endif
               end else begin
                  bit_idx_next = bit_idx_reg + 3'd1;
                  tx_next      = byte_reg[bit_idx_reg + 3'd1];
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (cnt_done) begin
               cnt_next   = '0;
               tx_next    = 1'b1;
               state_next = ST_STOP;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
`endif
         ST_STOP: begin
            if (cnt_done) begin
               cnt_next = '0;
               if (start_ok) begin
                  pop        = 1'b1;
                  byte_next  = mem[rd_ptr_reg];
                  tx_next    = 1'b0;
                  state_next = ST_START;
               end else begin
                  tx_next    = 1'b1;
                  state_next = ST_IDLE;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: begin
            cnt_next   = '0;
            tx_next    = 1'b1;
            state_next = ST_IDLE;
         end
      endcase
   end

   // Transmitter state registers.
   // Reset forces the line high at once and discards any partial frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= '0;
         bit_idx_reg <= 3'd0;
         byte_reg    <= 8'h00;
         tx_reg      <= 1'b1;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         bit_idx_reg <= bit_idx_next;
         byte_reg    <= byte_next;
         tx_reg      <= tx_next;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo (CLK_DIV=4, FIFO_DEPTH=4).
// The reference model keeps a byte queue and a queue of expected tx samples, one per clk.
// A frame is appended as a whole waveform when the line is free.
// A table of vectors covers the fill/overflow sequence.
// Hand-written sequences cover the single frame, back-to-back frames, mid-frame reset and parity.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

   localparam int CLK_DIV = 4;
   localparam int DEPTH   = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME = 11 * CLK_DIV;
`else
   localparam int FRAME = 10 * CLK_DIV;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ena = 1'b0;
   logic [7:0] din = 8'h00;
   logic       din_valid = 1'b0;
   logic       din_ready, tx, busy, overflow;
   logic [2:0] fifo_level;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [7:0] mq[$];     // bytes held by the FIFO
   logic       lq[$];     // expected tx level for the current and future cycles
   logic       m_ovf = 1'b0;

   logic tx_hist   [64];
   logic busy_hist [64];

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       e;
      logic [2:0] lvl;
      logic       rdy;
      logic       ovf;
   } vec_t;
   vec_t vt [6];

   uart_tx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .tx         (tx),
      .busy       (busy),
      .fifo_level (fifo_level),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      lq.delete();
      m_ovf = 1'b0;
   endtask

   // One clock edge of the model.
   // The pop decision uses the pre-push level; the push decision uses the pre-pop level.
   task automatic model_edge(input logic v, input logic [7:0] d, input logic e);
      int lvl0;
      logic [7:0] b;
      lvl0 = mq.size();
      if (lq.size() > 0) void'(lq.pop_front());
      if (lq.size() == 0 && e && lvl0 > 0) begin
         b = mq.pop_front();
         for (int k = 0; k < CLK_DIV; k++) lq.push_back(1'b0);
         for (int i = 0; i < 8; i++)
            for (int k = 0; k < CLK_DIV; k++) lq.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
         for (int k = 0; k < CLK_DIV; k++) lq.push_back(^b);
`endif
         for (int k = 0; k < CLK_DIV; k++) lq.push_back(1'b1);
      end
      if (v) begin
         if (lvl0 < DEPTH) mq.push_back(d);
         else m_ovf = 1'b1;
      end
   endtask

   task automatic compare_model();
      logic exp_tx;
      exp_tx = (lq.size() > 0) ? lq[0] : 1'b1;
      check("tx", 32'(tx), 32'(exp_tx));
      check("busy", 32'(busy), 32'(lq.size() > 0));
      check("fifo_level", 32'(fifo_level), 32'(mq.size()));
      check("din_ready", 32'(din_ready), 32'(mq.size() < DEPTH));
      check("overflow", 32'(overflow), 32'(m_ovf));
   endtask

   task automatic step(input logic v, input logic [7:0] d, input logic e);
      din_valid = v;
      din       = d;
      ena       = e;
      @(posedge clk);
      model_edge(v, d, e);
      #1;
      compare_model();
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      logic       rv, re;
      logic [7:0] rd;

      // 1. reset
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset tx", 32'(tx), 32'd1);
      check("reset busy", 32'(busy), 32'd0);
      check("reset fifo_level", 32'(fifo_level), 32'd0);
      check("reset overflow", 32'(overflow), 32'd0);
      check("reset din_ready", 32'(din_ready), 32'd1);
      rst = 1'b0;
      model_reset();
      $display("reset: tx=%0b busy=%0b level=%0d", tx, busy, fifo_level);

      // 2. single byte 0x55
      step(1'b1, 8'h55, 1'b1);
      for (int s = 1; s <= 45; s++) begin
         step(1'b0, 8'h00, 1'b1);
         tx_hist[s]   = tx;
         busy_hist[s] = busy;
      end
      check("single start N+1", 32'(tx_hist[1]), 32'd0);
      check("single start N+4", 32'(tx_hist[4]), 32'd0);
      check("single bit0", 32'(tx_hist[5]), 32'd1);
      check("single bit1", 32'(tx_hist[9]), 32'd0);
      check("single bit7", 32'(tx_hist[33]), 32'd0);
`ifndef UART_TX_PARITY_EN
      check("single stop", 32'(tx_hist[37]), 32'd1);
`endif
      check("single busy last", 32'(busy_hist[FRAME]), 32'd1);
      check("single busy end", 32'(busy_hist[FRAME + 1]), 32'd0);
      $display("single byte 0x55 sent");

      // 3. back-to-back bytes
      cnt = 0;
      step(1'b1, 8'hA0, 1'b1); cnt += int'(busy);
      step(1'b1, 8'h0F, 1'b1); cnt += int'(busy);
      step(1'b1, 8'hFF, 1'b1); cnt += int'(busy);
      for (int s = 0; s < 137; s++) begin
         step(1'b0, 8'h00, 1'b1);
         cnt += int'(busy);
      end
      check("back-to-back busy clks", 32'(cnt), 32'(3 * FRAME));
      $display("back-to-back: busy for %0d clks", cnt);

      // 4. overflow with ena low, then drain
      vt[0] = '{1'b1, 8'h11, 1'b0, 3'd1, 1'b1, 1'b0};
      vt[1] = '{1'b1, 8'h22, 1'b0, 3'd2, 1'b1, 1'b0};
      vt[2] = '{1'b1, 8'h33, 1'b0, 3'd3, 1'b1, 1'b0};
      vt[3] = '{1'b1, 8'h44, 1'b0, 3'd4, 1'b0, 1'b0};
      vt[4] = '{1'b1, 8'h55, 1'b0, 3'd4, 1'b0, 1'b1};
      vt[5] = '{1'b0, 8'h00, 1'b0, 3'd4, 1'b0, 1'b1};
      for (int i = 0; i < 6; i++) begin
         step(vt[i].v, vt[i].d, vt[i].e);
         check("vec fifo_level", 32'(fifo_level), 32'(vt[i].lvl));
         check("vec din_ready", 32'(din_ready), 32'(vt[i].rdy));
         check("vec overflow", 32'(overflow), 32'(vt[i].ovf));
         $display("vec %0d: din=%02h level=%0d ready=%0b ovf=%0b", i, vt[i].d, fifo_level, din_ready, overflow);
      end
      // Push while full and popping: the push must be refused.
      cnt = 0;
      step(1'b1, 8'h66, 1'b1); cnt += int'(busy);
      check("full push+pop level", 32'(fifo_level), 32'd3);
      check("full push+pop overflow", 32'(overflow), 32'd1);
      for (int s = 0; s < 199; s++) begin
         step(1'b0, 8'h00, 1'b1);
         cnt += int'(busy);
      end
      check("overflow drain busy clks", 32'(cnt), 32'(4 * FRAME));
      $display("overflow drain: busy for %0d clks", cnt);

      // 5. reset during DATA bit 3
      rst = 1'b1; #1; rst = 1'b0;
      model_reset();
      step(1'b1, 8'h00, 1'b1);
      step(1'b1, 8'h5A, 1'b1);
      for (int s = 0; s < 17; s++) step(1'b0, 8'h00, 1'b1);
      check("mid-frame tx before rst", 32'(tx), 32'd0);
      check("mid-frame level before rst", 32'(fifo_level), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("mid-frame rst tx", 32'(tx), 32'd1);
      check("mid-frame rst level", 32'(fifo_level), 32'd0);
      check("mid-frame rst busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      cnt = 0;
      for (int s = 0; s < 60; s++) begin
         step(1'b0, 8'h00, 1'b1);
         cnt += int'(busy);
      end
      check("after rst no frames", 32'(cnt), 32'd0);
      $display("reset mid-frame: busy clks afterwards %0d", cnt);

`ifdef UART_TX_PARITY_EN
      // 6. parity bit
      step(1'b1, 8'h07, 1'b1);
      for (int s = 1; s <= 46; s++) begin
         step(1'b0, 8'h00, 1'b1);
         tx_hist[s]   = tx;
         busy_hist[s] = busy;
      end
      check("parity 0x07", 32'(tx_hist[37]), 32'd1);
      check("parity frame busy last", 32'(busy_hist[44]), 32'd1);
      check("parity frame end", 32'(busy_hist[45]), 32'd0);
      step(1'b1, 8'h03, 1'b1);
      for (int s = 1; s <= 46; s++) begin
         step(1'b0, 8'h00, 1'b1);
         tx_hist[s] = tx;
      end
      check("parity 0x03", 32'(tx_hist[37]), 32'd0);
      $display("parity frames sent");
`endif

      // random traffic against the model
      for (int s = 0; s < 1500; s++) begin
         rv = ($urandom_range(0, 2) == 0);
         rd = 8'($urandom);
         re = ($urandom_range(0, 15) != 0);
         step(rv, rd, re);
      end
      $display("random phase done");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
